// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU types and constants
//   fp32_t      - IEEE-754 single-precision field view
//   div_state_t - sequential divider FSM states
package fpu_pkg;
    localparam int          BIAS         = 127;
    localparam logic [31:0] FP32_QNAN    = 32'hFFFFFFFF;
    localparam logic [7:0]  FP32_INF_EXP = 8'hFF;
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;
    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} div_state_t;
endpackage

// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: operand/result valid-ready handshake of the FP divider
//   master - issue side: drives in_valid, data1, data2, out_ready
//   slave  - divider side: drives in_ready, out_valid, result, div_by_zero
interface fp_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;
    modport master (output in_valid, data1, data2, out_ready,
                    input  in_ready, out_valid, result, div_by_zero);
    modport slave  (input  in_valid, data1, data2, out_ready,
                    output in_ready, out_valid, result, div_by_zero);
endinterface

// File: rtl/fp_classify.sv
// fp_classify: combinational IEEE-754 single operand classifier
//   i_op        - operand
//   o_is_zero   - +/-0
//   o_is_inf    - +/-infinity
//   o_is_nan    - any NaN
//   o_is_denorm - subnormal (nonzero fraction, zero exponent)
module fp_classify
    import fpu_pkg::*;
(
    input  fp32_t i_op,
    output logic  o_is_zero,
    output logic  o_is_inf,
    output logic  o_is_nan,
    output logic  o_is_denorm
);
    logic w_exp_min, w_exp_max, w_frac_zero;
    assign w_exp_min   = i_op.exp == '0;
    assign w_exp_max   = i_op.exp == FP32_INF_EXP;
    assign w_frac_zero = i_op.frac == '0;
    assign o_is_zero   = w_exp_min & w_frac_zero;
    assign o_is_denorm = w_exp_min & ~w_frac_zero;
    assign o_is_inf    = w_exp_max & w_frac_zero;
    assign o_is_nan    = w_exp_max & ~w_frac_zero;
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: iterative radix-2 restoring IEEE-754 single-precision divider (data1 / data2)
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - slave side of fp_div_seq_if: operands in on in_valid/in_ready,
//          result and div_by_zero out on out_valid/out_ready
module fp_div_seq #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input logic         CLK,
    input logic         nRST,
    fp_div_seq_if.slave bus
);
    import fpu_pkg::*;
    localparam int MW = MANT_W + 1;
    localparam int QW = MANT_W + 3;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW);

    div_state_t           r_state;
    logic                 r_in_ready, r_out_valid, r_dbz, r_ld;
    logic [31:0]          r_result;
    fp32_t                r_a, r_b;
    logic [MW:0]          r_rem;
    logic [MW-1:0]        r_mb;
    logic [QW-1:0]        r_q;
    logic signed [EW-1:0] r_e;
    logic [CW-1:0]        r_cnt;

    logic w_a_zero, w_a_inf, w_a_nan, w_a_dn;
    logic w_b_zero, w_b_inf, w_b_nan, w_b_dn;

    fp_classify u_cls_a (.i_op(r_a), .o_is_zero(w_a_zero), .o_is_inf(w_a_inf),
                         .o_is_nan(w_a_nan), .o_is_denorm(w_a_dn));
    fp_classify u_cls_b (.i_op(r_b), .o_is_zero(w_b_zero), .o_is_inf(w_b_inf),
                         .o_is_nan(w_b_nan), .o_is_denorm(w_b_dn));

    // Denormals are flushed to zero before the special-case priority is applied.
    logic        w_a_z, w_b_z, w_sign, w_nan, w_special, w_dbz;
    logic [31:0] w_spec_res;
    assign w_a_z      = w_a_zero | w_a_dn;
    assign w_b_z      = w_b_zero | w_b_dn;
    assign w_sign     = r_a.sign ^ r_b.sign;
    assign w_nan      = w_a_nan | w_b_nan | (w_a_z & w_b_z) | (w_a_inf & w_b_inf);
    assign w_special  = w_nan | w_a_z | w_b_z | w_a_inf | w_b_inf;
    assign w_dbz      = ~w_nan & w_b_z & ~w_a_inf;
    assign w_spec_res = w_nan ? FP32_QNAN :
                        (w_b_z | w_a_inf) ? {w_sign, FP32_INF_EXP, MANT_W'(0)} :
                        {w_sign, (EXP_W + MANT_W)'(0)};

    logic signed [EW-1:0] w_e0;
    assign w_e0 = EW'(r_a.exp) - EW'(r_b.exp) + EW'(BIAS);

    // Restoring step: remainder stays below the divisor, so a non-subtracting
    // step never needs the top remainder bit.
    logic          w_ge;
    logic [MW-1:0] w_diff;
    assign w_ge   = r_rem >= {1'b0, r_mb};
    assign w_diff = w_ge ? MW'(r_rem - {1'b0, r_mb}) : r_rem[MW-1:0];

    logic                 w_hi, w_g, w_s, w_inc;
    logic [MW-1:0]        w_nm;
    logic [MW:0]          w_mr;
    logic signed [EW-1:0] w_er;
    logic [31:0]          w_pk;
    assign w_hi  = r_q[QW-1];
    assign w_nm  = w_hi ? r_q[QW-1:2] : r_q[QW-2:1];
    assign w_g   = w_hi ? r_q[1] : r_q[0];
    assign w_s   = (w_hi & r_q[0]) | (r_rem != '0);
    assign w_inc = w_g & (w_s | w_nm[0]);
    assign w_mr  = {1'b0, w_nm} + (MW + 1)'(w_inc);
    // A mantissa carry leaves the low fraction bits zero, i.e. exactly 1.0.
    assign w_er  = r_e - EW'(!w_hi) + EW'(w_mr[MW]);
    assign w_pk  = (w_er >= EW'(2 ** EXP_W - 1)) ? {w_sign, FP32_INF_EXP, MANT_W'(0)} :
                   (w_er <= EW'(0)) ? {w_sign, (EXP_W + MANT_W)'(0)} :
                   {w_sign, w_er[EXP_W-1:0], w_mr[MANT_W-1:0]};

    // The first DIVIDE cycle (r_ld) classifies the latched operands and either
    // finishes a special case or seeds the iteration.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_dbz       <= 1'b0;
            r_ld        <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_mb        <= '0;
            r_q         <= '0;
            r_e         <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.in_valid) begin
                    r_a        <= bus.data1;
                    r_b        <= bus.data2;
                    r_ld       <= 1'b1;
                    r_in_ready <= 1'b0;
                    r_state    <= DIVIDE;
                end
                DIVIDE: if (r_ld) begin
                    r_ld <= 1'b0;
                    if (w_special) begin
                        r_result    <= w_spec_res;
                        r_dbz       <= w_dbz;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_rem <= {2'b01, r_a.frac};
                        r_mb  <= {1'b1, r_b.frac};
                        r_q   <= '0;
                        r_e   <= w_e0;
                        r_cnt <= CW'(QW - 1);
                    end
                end else begin
                    r_rem <= {w_diff, 1'b0};
                    r_q   <= {r_q[QW-2:0], w_ge};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= ROUND;
                end
                ROUND: begin
                    r_result    <= w_pk;
                    r_dbz       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed table-driven bench for fp_div_seq
module tb_fp_div_seq;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    fp_div_seq_if bus();
    fp_div_seq dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t v[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic dbz, output int lat);
        @(negedge CLK);
        bus.data1 = a;
        bus.data2 = b;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge CLK);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!bus.out_valid && lat < 100);
        res = bus.result;
        dbz = bus.div_by_zero;
    endtask

    task automatic release_out;
        @(negedge CLK) bus.out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK) bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        dbz;
        int          lat;
        v[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 28};
        v[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 28};
        v[2]  = '{32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 28};
        v[3]  = '{32'h40A00000, 32'h80000000, 32'hFF800000, 1'b1, 1};
        v[4]  = '{32'h40ACCCCD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1};
        v[5]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 28};
        v[6]  = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 1'b0, 28};
        v[7]  = '{32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 1'b0, 28};
        v[8]  = '{32'h80800000, 32'h40000000, 32'h80000000, 1'b0, 28};
        v[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 1'b0, 1};
        v[10] = '{32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1};
        v[11] = '{32'hFF800000, 32'h7F800000, 32'hFFFFFFFF, 1'b0, 1};
        v[12] = '{32'h80000000, 32'h40A00000, 32'h80000000, 1'b0, 1};
        v[13] = '{32'h40400000, 32'hFF800000, 32'h80000000, 1'b0, 1};
        v[14] = '{32'h00000001, 32'h3F800000, 32'h00000000, 1'b0, 1};
        v[15] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 1'b1, 1};
        v[16] = '{32'h3FFFFFFF, 32'h3F7FFFFF, 32'h40000000, 1'b0, 28};
        v[17] = '{32'h7FC00000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1};
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.data1 = '0;
        bus.data2 = '0;
        #12;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge CLK) nRST = 1'b1;
        for (int i = 0; i < 18; i++) begin
            run_op(v[i].a, v[i].b, res, dbz, lat);
            chk($sformatf("vec%0d_result", i), res, v[i].res);
            chk($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(v[i].dbz));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v[i].lat));
            release_out();
        end
        run_op(32'h40C00000, 32'h40000000, res, dbz, lat);
        chk("bp_first_result", res, 32'h40400000);
        @(negedge CLK);
        bus.in_valid = 1'b1;
        bus.data1 = 32'h3F800000;
        bus.data2 = 32'h40400000;
        for (int k = 0; k < 5; k++) begin
            @(posedge CLK);
            #1;
            chk("bp_result_stable", bus.result, 32'h40400000);
            chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        end
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge CLK) bus.out_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("bp_ignored_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_ignored_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge CLK);
        bus.data1 = 32'h40C00000;
        bus.data2 = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge CLK);
        #1 bus.in_valid = 1'b0;
        repeat (11) @(posedge CLK);
        #2;
        chk("rst_busy_in_ready", 32'(bus.in_ready), 32'd0);
        nRST = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge CLK) nRST = 1'b1;
        run_op(32'h40C00000, 32'h40000000, res, dbz, lat);
        chk("post_rst_result", res, 32'h40400000);
        chk("post_rst_latency", 32'(lat), 32'd28);
        release_out();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
